// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay scheduler.
//   state_t   : scheduler FSM state (IDLE / RUN / DONE)
//   MODE_FORK : all enabled channels timed from the launch edge
//   MODE_SEQ  : enabled channels chained in ascending index order
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FORK = 1'b0;
    localparam logic MODE_SEQ  = 1'b1;

endpackage

// File: rtl/delay_sched_chan.sv
// One scheduled channel: holds its captured delay/value, counts down once
// armed and loads its output register on the fire edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   capture    : latch delay_in/data_in (launch edge)
//   delay_in   : delay for this channel
//   data_in    : value for this channel
//   arm        : start the countdown on this edge
//   kill       : cancel any countdown; suppresses a coincident fire
//   fire       : combinational, this edge is the fire edge
//   active     : countdown in progress
//   out_data   : registered value, changes only when firing
//   out_valid  : one-cycle pulse after the fire edge
module delay_sched_chan #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [CW-1:0] delay_in,
    input  logic [DW-1:0] data_in,
    input  logic          arm,
    input  logic          kill,
    output logic          fire,
    output logic          active,
    output logic [DW-1:0] out_data,
    output logic          out_valid
);

    logic [CW-1:0] d_reg;
    logic [DW-1:0] data_reg;
    logic [CW-1:0] cnt;

    // Armed at edge X with delay d: cnt reaches 0 at X+d, fire at X+d+1.
    assign fire = active && (cnt == '0) && !kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg     <= '0;
            data_reg  <= '0;
            cnt       <= '0;
            active    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= fire;
            if (capture) begin
                d_reg    <= delay_in;
                data_reg <= data_in;
            end
            if (fire) begin
                out_data <= data_reg;
                active   <= 1'b0;
            end
            if (kill)
                active <= 1'b0;
            if (arm) begin
                // On the launch edge the captured copy is not yet visible.
                active <= 1'b1;
                cnt    <= capture ? delay_in : d_reg;
            end else if (active && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Multi-channel delay scheduler. A launch captures per-channel delays and
// values; each enabled channel later loads its value into out_data and
// pulses out_valid. FORK times every channel from launch, SEQ chains them.
// Handshake: start is a one-cycle request with no ready; it is accepted
// only in IDLE and silently dropped in RUN/DONE.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, mode, ch_en  : launch request, FORK/SEQ, channel enable mask
//   cmd_delay, cmd_data : per-channel delay and value (sampled with start)
//   abort               : cancel a running schedule
//   out_data, out_valid : per-channel result and update pulse
//   busy, done          : schedule in progress, one-cycle join pulse
//   fsm_state           : current FSM state for observation
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int CW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*CW-1:0] cmd_delay,
    input  logic [NCH*DW-1:0] cmd_data,
    input  logic              abort,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);

    state_t         state;
    logic           mode_reg;
    logic [NCH-1:0] en_reg;
    logic           launch;
    logic           kill;
    logic           mode_eff;
    logic [NCH-1:0] en_eff;
    logic [NCH-1:0] arm;
    logic [NCH-1:0] fire;
    logic [NCH-1:0] active;

    assign launch    = (state == IDLE) && start;
    assign kill      = (state == RUN) && abort;
    assign mode_eff  = launch ? mode  : mode_reg;
    assign en_eff    = launch ? ch_en : en_reg;
    assign fsm_state = state;

    // SEQ token: starts at launch, is taken over by each enabled channel's
    // fire, and passes straight through disabled channels (zero time).
    always_comb begin
        logic tok;
        tok = launch;
        arm = '0;
        for (int i = 0; i < NCH; i++) begin
            arm[i] = en_eff[i] && ((mode_eff == MODE_SEQ) ? tok : launch);
            if (en_eff[i])
                tok = fire[i];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        delay_sched_chan #(.DW(DW), .CW(CW)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .capture   (launch),
            .delay_in  (cmd_delay[g*CW +: CW]),
            .data_in   (cmd_data[g*DW +: DW]),
            .arm       (arm[g]),
            .kill      (kill),
            .fire      (fire[g]),
            .active    (active[g]),
            .out_data  (out_data[g*DW +: DW]),
            .out_valid (out_valid[g])
        );
    end

    // Join: once no channel is counting, the last fire happened on the
    // previous edge (or nothing was enabled), so enter DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_reg <= MODE_FORK;
            en_reg   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (launch) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        mode_reg <= mode;
                        en_reg   <= ch_en;
                    end
                end
                RUN: begin
                    if (kill) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (active == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sched.sv
module tb_delay_sched;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 8;

    typedef struct {
        int          at;
        int          ch;
        logic [7:0]  val;
    } ev_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [NCH-1:0]    ch_en;
    logic [NCH*CW-1:0] cmd_delay;
    logic [NCH*DW-1:0] cmd_data;
    logic              abort;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]    out_valid;
    logic              busy;
    logic              done;
    logic [1:0]        fsm_state;

    ev_t               exp_q[$];
    logic [NCH*DW-1:0] exp_data;
    logic [NCH-1:0]    ev_v;
    logic              ev_done;
    int cyc;
    int e0;
    int end_edge;
    int busy_lo;
    int busy_hi;
    int tests;
    int fails;

    delay_sched #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .ch_en     (ch_en),
        .cmd_delay (cmd_delay),
        .cmd_data  (cmd_data),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset / edge counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Scoreboard: events whose edge has come are popped and compared.
    always @(posedge clk) begin
        #1;
        ev_v    = '0;
        ev_done = 1'b0;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].at == cyc) begin
                if (exp_q[k].ch < 0) begin
                    ev_done = 1'b1;
                end else begin
                    ev_v[exp_q[k].ch] = 1'b1;
                    exp_data[exp_q[k].ch*DW +: DW] = exp_q[k].val;
                end
                exp_q.delete(k);
            end
        end
        chk("out_valid", 32'(out_valid), 32'(ev_v));
        chk("done", 32'(done), 32'(ev_done));
        chk("out_data", 32'(out_data), 32'(exp_data));
        chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic launch(input logic m, input logic [3:0] en,
                          input logic [31:0] dly, input logic [31:0] dat);
        int f;
        int last;
        int at;
        ev_t ev;
        mode      = m;
        ch_en     = en;
        cmd_delay = dly;
        cmd_data  = dat;
        start     = 1'b1;
        e0   = cyc + 1;
        f    = e0;
        last = e0;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) begin
                at = (m ? f : e0) + int'(dly[i*CW +: CW]) + 1;
                if (m) f = at;
                if (at > last) last = at;
                ev.at = at; ev.ch = i; ev.val = dat[i*DW +: DW];
                exp_q.push_back(ev);
            end
        end
        ev.at = last + 1; ev.ch = -1; ev.val = '0;
        exp_q.push_back(ev);
        busy_lo  = e0;
        busy_hi  = last + 1;
        end_edge = last + 1;
        @(negedge clk);
        start     = 1'b0;
        mode      = ~m;
        ch_en     = 4'($urandom);
        cmd_delay = $urandom;
        cmd_data  = $urandom;
    endtask

    task automatic poke_start();
        start     = 1'b1;
        mode      = 1'b0;
        ch_en     = 4'hf;
        cmd_delay = '0;
        cmd_data  = $urandom;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_end();
        wait_cyc(end_edge + 2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; ch_en = '0;
        cmd_delay = '0; cmd_data = '0; abort = 1'b0;
        exp_data = '0; busy_lo = 1; busy_hi = 0; end_edge = 0; e0 = 0;

        repeat (3) @(negedge clk);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // FORK, two channels, ch1 first
        launch(1'b0, 4'b0011, {8'd0, 8'd0, 8'd15, 8'd20}, {8'h00, 8'h00, 8'h01, 8'h00});
        wait_cyc(e0 + 5);
        poke_start();
        wait_end();

        // SEQ chained, with an ignored start in the middle
        launch(1'b1, 4'b0011, {8'd0, 8'd0, 8'd30, 8'd10}, {8'h00, 8'h00, 8'hb1, 8'ha0});
        wait_cyc(e0 + 20);
        poke_start();
        wait_end();
        chk("seq_idle", 32'(fsm_state), 32'd0);

        // FORK, all channels equal delay
        launch(1'b0, 4'b1111, {8'd5, 8'd5, 8'd5, 8'd5}, {8'h44, 8'h33, 8'h22, 8'h11});
        wait_end();

        // SEQ with holes; ch0/ch2 keep previous values
        launch(1'b1, 4'b1010, {8'd4, 8'd9, 8'd3, 8'd7}, {8'hd3, 8'h77, 8'hc1, 8'h66});
        wait_end();

        // abort mid-run, then an all-disabled launch
        launch(1'b1, 4'b0011, {8'd0, 8'd0, 8'd30, 8'd10}, {8'h00, 8'h00, 8'h5a, 8'ha5});
        wait_cyc(e0 + 8);
        abort = 1'b1;
        for (int k = exp_q.size() - 1; k >= 0; k--)
            if (exp_q[k].at >= e0 + 9) exp_q.delete(k);
        busy_hi = e0 + 8;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'(fsm_state), 32'd0);
        launch(1'b0, 4'b0000, 32'h01020304, 32'h99999999);
        wait_end();

        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_noop", 32'(fsm_state), 32'd0);

        // reset mid-run
        launch(1'b1, 4'b0011, {8'd0, 8'd0, 8'd30, 8'd10}, {8'h00, 8'h00, 8'h3c, 8'hc3});
        wait_cyc(e0 + 12);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_data = '0;
        busy_hi = 0; busy_lo = 1;
        #1;
        chk("rst_mid_out_data", 32'(out_data), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        // start on the first edge after reset release
        rst_n = 1'b1;
        launch(1'b0, 4'b0100, {8'd0, 8'd2, 8'd0, 8'd0}, {8'h00, 8'he7, 8'h00, 8'h00});
        wait_end();

        // random runs, small delays including zero
        for (int r = 0; r < 6; r++) begin
            launch(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                    8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))},
                   $urandom);
            wait_end();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
